// File: rtl/status_register.sv
// 6502 processor status register P (N V 1 B D I Z C).
// Captures ALU flags, PLP/RTI/BIT loads, SEx/CLx and builds the pushed byte.
module status_register #(
  parameter logic [7:0] RESET_P   = 8'h34,
  parameter bit         DELAYED_I = 1'b1
) (
  input  logic       clk,
  input  logic       reset_N,
  input  logic       alu_carry_IN,
  input  logic       alu_overflow_IN,
  input  logic       alu_negative_IN,
  input  logic       alu_zero_IN,
  input  logic [7:0] data_bus_IN,
  input  logic       update_nz_EN,
  input  logic       update_c_EN,
  input  logic       update_v_EN,
  input  logic       bit_EN,
  input  logic       load_bus_EN,
  input  logic       set_c_EN,
  input  logic       clr_c_EN,
  input  logic       set_i_EN,
  input  logic       clr_i_EN,
  input  logic       set_d_EN,
  input  logic       clr_d_EN,
  input  logic       clr_v_EN,
  input  logic       inst_boundary_IN,
  input  logic       push_brk_IN,
  output logic [7:0] status_REG_OUT,
  output logic [7:0] push_REG_OUT,
  output logic       carry_FLAG_OUT,
  output logic       decimal_FLAG_OUT,
  output logic       irq_mask_OUT,
  output logic       conflict_ERR_OUT
);

  logic r_n;
  logic r_v;
  logic r_d;
  logic r_i;
  logic r_z;
  logic r_c;
  logic r_err;

  logic w_n;
  logic w_v;
  logic w_d;
  logic w_i;
  logic w_z;
  logic w_c;
  logic w_c_cf;
  logic w_i_cf;
  logic w_d_cf;
  logic w_err;

  assign w_c_cf = set_c_EN & clr_c_EN;
  assign w_i_cf = set_i_EN & clr_i_EN;
  assign w_d_cf = set_d_EN & clr_d_EN;

  // A bus load resolves every conflicting flag, so no error is raised then.
  assign w_err = ~load_bus_EN & (w_c_cf | w_i_cf | w_d_cf);

  // Next-state of each flag, resolved by source priority.
  always_comb begin
    w_n = r_n;
    w_v = r_v;
    w_d = r_d;
    w_i = r_i;
    w_z = r_z;
    w_c = r_c;

    if (load_bus_EN) begin
      w_n = data_bus_IN[7];
    end else if (bit_EN) begin
      w_n = data_bus_IN[7];
    end else if (update_nz_EN) begin
      w_n = alu_negative_IN;
    end

    if (load_bus_EN) begin
      w_z = data_bus_IN[1];
    end else if (bit_EN | update_nz_EN) begin
      w_z = alu_zero_IN;
    end

    if (load_bus_EN) begin
      w_v = data_bus_IN[6];
    end else if (clr_v_EN) begin
      w_v = 1'b0;
    end else if (bit_EN) begin
      w_v = data_bus_IN[6];
    end else if (update_v_EN) begin
      w_v = alu_overflow_IN;
    end

    if (load_bus_EN) begin
      w_c = data_bus_IN[0];
    end else if (w_c_cf) begin
      w_c = r_c;
    end else if (set_c_EN) begin
      w_c = 1'b1;
    end else if (clr_c_EN) begin
      w_c = 1'b0;
    end else if (update_c_EN) begin
      w_c = alu_carry_IN;
    end

    if (load_bus_EN) begin
      w_i = data_bus_IN[2];
    end else if (!w_i_cf && set_i_EN) begin
      w_i = 1'b1;
    end else if (!w_i_cf && clr_i_EN) begin
      w_i = 1'b0;
    end

    if (load_bus_EN) begin
      w_d = data_bus_IN[3];
    end else if (!w_d_cf && set_d_EN) begin
      w_d = 1'b1;
    end else if (!w_d_cf && clr_d_EN) begin
      w_d = 1'b0;
    end
  end

  // Flag storage and the one-cycle conflict pulse.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_n   <= RESET_P[7];
      r_v   <= RESET_P[6];
      r_d   <= RESET_P[3];
      r_i   <= RESET_P[2];
      r_z   <= RESET_P[1];
      r_c   <= RESET_P[0];
      r_err <= 1'b0;
    end else begin
      r_n   <= w_n;
      r_v   <= w_v;
      r_d   <= w_d;
      r_i   <= w_i;
      r_z   <= w_z;
      r_c   <= w_c;
      r_err <= w_err;
    end
  end

  generate
    if (DELAYED_I) begin : g_dly_i
      logic r_irq;
      // Interrupt mask tracks I only at instruction boundaries.
      always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
          r_irq <= RESET_P[2];
        end else if (inst_boundary_IN) begin
          r_irq <= w_i;
        end
      end
      assign irq_mask_OUT = r_irq;
    end else begin : g_live_i
      assign irq_mask_OUT = r_i;
    end
  endgenerate

  assign status_REG_OUT   = {r_n, r_v, 2'b11, r_d, r_i, r_z, r_c};
  assign push_REG_OUT     = {r_n, r_v, 1'b1, push_brk_IN,
                             r_d, r_i, r_z, r_c};
  assign carry_FLAG_OUT   = r_c;
  assign decimal_FLAG_OUT = r_d;
  assign conflict_ERR_OUT = r_err;

endmodule

// File: tb/tb_status_register.sv
// Bench for status_register: directed 6502 scenarios plus
// randomized traffic against a layered behavioural model.
module tb_status_register;

  logic       clk;
  logic       rst_n;
  logic       a_c, a_v, a_n, a_z;
  logic [7:0] bus;
  logic       e_nz, e_c, e_v, e_bit, e_ld;
  logic       s_c, c_c, s_i, c_i, s_d, c_d, c_v;
  logic       bnd, brk;

  logic [7:0] st1, pu1, st0, pu0;
  logic       cy1, dc1, irq1, err1;
  logic       cy0, dc0, irq0, err0;

  int n_checks;
  int n_fail;
  bit cmp_en;

  logic [7:0] m_p;
  logic       m_irq;
  logic       m_err;

  status_register #(.RESET_P(8'h34), .DELAYED_I(1'b1)) dut (
    .clk(clk), .reset_N(rst_n),
    .alu_carry_IN(a_c), .alu_overflow_IN(a_v),
    .alu_negative_IN(a_n), .alu_zero_IN(a_z),
    .data_bus_IN(bus),
    .update_nz_EN(e_nz), .update_c_EN(e_c), .update_v_EN(e_v),
    .bit_EN(e_bit), .load_bus_EN(e_ld),
    .set_c_EN(s_c), .clr_c_EN(c_c),
    .set_i_EN(s_i), .clr_i_EN(c_i),
    .set_d_EN(s_d), .clr_d_EN(c_d), .clr_v_EN(c_v),
    .inst_boundary_IN(bnd), .push_brk_IN(brk),
    .status_REG_OUT(st1), .push_REG_OUT(pu1),
    .carry_FLAG_OUT(cy1), .decimal_FLAG_OUT(dc1),
    .irq_mask_OUT(irq1), .conflict_ERR_OUT(err1)
  );

  status_register #(.RESET_P(8'h34), .DELAYED_I(1'b0)) dut0 (
    .clk(clk), .reset_N(rst_n),
    .alu_carry_IN(a_c), .alu_overflow_IN(a_v),
    .alu_negative_IN(a_n), .alu_zero_IN(a_z),
    .data_bus_IN(bus),
    .update_nz_EN(e_nz), .update_c_EN(e_c), .update_v_EN(e_v),
    .bit_EN(e_bit), .load_bus_EN(e_ld),
    .set_c_EN(s_c), .clr_c_EN(c_c),
    .set_i_EN(s_i), .clr_i_EN(c_i),
    .set_d_EN(s_d), .clr_d_EN(c_d), .clr_v_EN(c_v),
    .inst_boundary_IN(bnd), .push_brk_IN(brk),
    .status_REG_OUT(st0), .push_REG_OUT(pu0),
    .carry_FLAG_OUT(cy0), .decimal_FLAG_OUT(dc0),
    .irq_mask_OUT(irq0), .conflict_ERR_OUT(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: lower-priority sources are applied first and then
  // overwritten by higher-priority ones; a set+clr pair restores old.
  always @(posedge clk or negedge rst_n) begin
    logic [7:0] p;
    logic [7:0] np;
    if (!rst_n) begin
      m_p   = 8'h34;
      m_irq = 1'b1;
      m_err = 1'b0;
    end else begin
      p  = m_p;
      np = p;
      if (e_nz) begin np[7] = a_n; np[1] = a_z; end
      if (e_c) np[0] = a_c;
      if (e_v) np[6] = a_v;
      if (e_bit) begin
        np[7] = bus[7]; np[6] = bus[6]; np[1] = a_z;
      end
      if (s_c && c_c) np[0] = p[0];
      else if (s_c) np[0] = 1'b1;
      else if (c_c) np[0] = 1'b0;
      if (s_i && c_i) np[2] = p[2];
      else if (s_i) np[2] = 1'b1;
      else if (c_i) np[2] = 1'b0;
      if (s_d && c_d) np[3] = p[3];
      else if (s_d) np[3] = 1'b1;
      else if (c_d) np[3] = 1'b0;
      if (c_v) np[6] = 1'b0;
      if (e_ld) np = bus | 8'h30;
      m_err = !e_ld && ((s_c && c_c) || (s_i && c_i) || (s_d && c_d));
      if (bnd) m_irq = np[2];
      m_p = np;
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("status", st1, m_p);
      check("push", pu1, {m_p[7:5], brk, m_p[3:0]});
      check("carry", {7'd0, cy1}, {7'd0, m_p[0]});
      check("decimal", {7'd0, dc1}, {7'd0, m_p[3]});
      check("irq_mask", {7'd0, irq1}, {7'd0, m_irq});
      check("conflict", {7'd0, err1}, {7'd0, m_err});
      check("status_nd", st0, m_p);
      check("irq_mask_nd", {7'd0, irq0}, {7'd0, m_p[2]});
      check("conflict_nd", {7'd0, err0}, {7'd0, m_err});
    end
  end

  task automatic idle();
    a_c = 0; a_v = 0; a_n = 0; a_z = 0; bus = 8'h00;
    e_nz = 0; e_c = 0; e_v = 0; e_bit = 0; e_ld = 0;
    s_c = 0; c_c = 0; s_i = 0; c_i = 0; s_d = 0; c_d = 0; c_v = 0;
    bnd = 0;
  endtask

  // Advance one clock; return just after the sampling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cmp_en   = 0;
    brk      = 1'b1;
    idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    step();
    cmp_en = 1;

    // Async reset mid-cycle after some traffic.
    s_c = 1; s_d = 1; step(); idle();
    #2 rst_n = 1'b0;
    #1;
    check("rst_status", st1, 8'h34);
    rst_n = 1'b1;
    step();
    check("rst_status2", st1, 8'h34);
    check("rst_irq", {7'd0, irq1}, 8'h01);
    check("rst_carry", {7'd0, cy1}, 8'h00);
    check("rst_push1", pu1, 8'h34);
    brk = 0; #1;
    check("rst_push0", pu1, 8'h24);

    // ADC-style update.
    a_c = 1; a_v = 1; a_n = 0; a_z = 1;
    e_nz = 1; e_c = 1; e_v = 1;
    step(); idle();
    check("adc_status", st1, 8'h77);
    check("adc_carry", {7'd0, cy1}, 8'h01);
    step();
    check("adc_hold", st1, 8'h77);

    // PLP with a competing clear of C.
    bus = 8'hCB; e_ld = 1; c_c = 1;
    step(); idle();
    check("plp_status", st1, 8'hFB);
    check("plp_err", {7'd0, err1}, 8'h00);

    // BIT overrides NZ update.
    bus = 8'h40; a_z = 1; a_n = 1; e_bit = 1; e_nz = 1;
    step(); idle();
    check("bit_status", st1, 8'h7B);

    // D conflict.
    c_d = 1; step(); idle();
    check("cld", st1, 8'h73);
    s_d = 1; c_d = 1; step(); idle();
    check("cf_status", st1, 8'h73);
    check("cf_err", {7'd0, err1}, 8'h01);
    step();
    check("cf_err_end", {7'd0, err1}, 8'h00);

    // Interrupt mask latency.
    s_i = 1; bnd = 1; step(); idle();
    check("sei_irq", {7'd0, irq1}, 8'h01);
    c_i = 1; step(); idle();
    check("cli_status", st1, 8'h73);
    check("cli_irq_hold", {7'd0, irq1}, 8'h01);
    step();
    check("cli_irq_hold2", {7'd0, irq1}, 8'h01);
    bnd = 1; step(); idle();
    check("cli_irq_bnd", {7'd0, irq1}, 8'h00);
    s_i = 1; bnd = 1; step(); idle();
    check("sei_irq2", {7'd0, irq1}, 8'h01);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      a_c   = 1'($urandom); a_v = 1'($urandom);
      a_n   = 1'($urandom); a_z = 1'($urandom);
      bus   = 8'($urandom);
      brk   = 1'($urandom);
      e_nz  = ($urandom_range(0, 3) == 0);
      e_c   = ($urandom_range(0, 3) == 0);
      e_v   = ($urandom_range(0, 3) == 0);
      e_bit = ($urandom_range(0, 7) == 0);
      e_ld  = ($urandom_range(0, 9) == 0);
      s_c   = ($urandom_range(0, 5) == 0);
      c_c   = ($urandom_range(0, 5) == 0);
      s_i   = ($urandom_range(0, 5) == 0);
      c_i   = ($urandom_range(0, 5) == 0);
      s_d   = ($urandom_range(0, 5) == 0);
      c_d   = ($urandom_range(0, 5) == 0);
      c_v   = ($urandom_range(0, 7) == 0);
      bnd   = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
